// File: rtl/sync_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_gate_pkg
// Description : Shared types and constants for the synchroniser gate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_gate_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int C_CNT_W_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : 3-flop synchroniser with rising-edge event output.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    output logic o_event
);

    logic [2:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_strobe};
        end
    end

    // Event when old/mid/new = 0/1/1; consumed by the next clock edge.
    assign o_event = ~r_sync[2] & r_sync[1] & r_sync[0];

endmodule
`default_nettype wire

// File: rtl/sync_gate_gen.sv
`default_nettype none
// ============================================================================
// Module      : sync_gate_gen
// Description : Multi-channel radar gate generator driven by tick and
//               cycle-start strobes, with per-cycle start scanning.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_gate_gen
    import sync_gate_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = C_CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 t8us,
    input  logic                 tnc,
    input  logic                 arm,
    input  logic [NCH*CNT_W-1:0] cfg_start,
    input  logic [NCH*CNT_W-1:0] cfg_len,
    input  logic [NCH*CNT_W-1:0] cfg_step,
    output logic [NCH-1:0]       gate,
    output logic [NCH-1:0]       gate_on,
    output logic [NCH-1:0]       gate_off,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [CNT_W-1:0]     tick_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_tnc_ev;
    logic             w_tick_ev;
    logic             w_load;
    logic             w_restart;
    logic             w_abort;
    logic             w_run_tick;
    logic             w_sat_nxt;
    logic             w_done_nxt;
    logic             r_done;
    logic             r_overrun;
    logic [NCH-1:0]   w_fin_nxt;

    sync_edge_det u_tick_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_strobe (t8us),
        .o_event  (w_tick_ev)
    );

    sync_edge_det u_tnc_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_strobe (tnc),
        .o_event  (w_tnc_ev)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tnc_ev && arm) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!arm)                           w_state_nxt = ST_IDLE;
                else if (w_tnc_ev)                  w_state_nxt = ST_RUN;
                else if ((&w_fin_nxt) || w_sat_nxt) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A cycle-start event always beats a coincident tick.
    always_comb begin
        w_load     = w_tnc_ev & arm;
        w_restart  = (r_state == ST_RUN) & arm & w_tnc_ev;
        w_abort    = (r_state == ST_RUN) & ~arm;
        w_run_tick = (r_state == ST_RUN) & arm & ~w_tnc_ev & w_tick_ev;
    end

    assign w_done_nxt = (r_state == ST_RUN) && (w_state_nxt == ST_IDLE);
    assign w_cnt_inc  = (r_tick_cnt == C_CNT_MAX) ? r_tick_cnt : r_tick_cnt + 1'b1;
    assign w_sat_nxt  = w_run_tick && (w_cnt_inc == C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_load) begin
                r_tick_cnt <= '0;
            end else if (w_run_tick) begin
                r_tick_cnt <= w_cnt_inc;
            end
            if (!arm) begin
                r_overrun <= 1'b0;
            end else if (w_restart) begin
                r_overrun <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic [CNT_W-1:0] w_start;
        logic [CNT_W-1:0] w_len_cfg;
        logic [CNT_W-1:0] w_step;
        logic [CNT_W:0]   w_s_new;
        logic [CNT_W:0]   w_end;
        logic [CNT_W-1:0] r_offset;
        logic [CNT_W-1:0] r_len;
        logic [CNT_W:0]   r_s;
        logic             r_gate;
        logic             r_gate_on;
        logic             r_gate_off;
        logic             r_fin;
        logic             w_open0;
        logic             w_hit_open;
        logic             w_hit_close;

        assign w_start   = cfg_start[gi*CNT_W +: CNT_W];
        assign w_len_cfg = cfg_len[gi*CNT_W +: CNT_W];
        assign w_step    = cfg_step[gi*CNT_W +: CNT_W];

        // Start and end points carry an extra bit so far-out gates never alias.
        assign w_s_new = {1'b0, w_start} + {1'b0, r_offset};
        assign w_end   = r_s + {1'b0, r_len};

        assign w_open0     = (w_s_new == '0) && (w_len_cfg != '0);
        assign w_hit_open  = w_run_tick && ({1'b0, w_cnt_inc} == r_s) && (r_len != '0);
        assign w_hit_close = w_run_tick && (r_gate || w_hit_open) &&
                             (({1'b0, w_cnt_inc} == w_end) || w_sat_nxt);
        assign w_fin_nxt[gi] = r_fin | w_hit_close;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_offset <= '0;
            end else if (!arm) begin
                r_offset <= '0;
            end else if (w_load) begin
                r_offset <= r_offset + w_step;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_s        <= '0;
                r_len      <= '0;
                r_gate     <= 1'b0;
                r_gate_on  <= 1'b0;
                r_gate_off <= 1'b0;
                r_fin      <= 1'b0;
            end else begin
                r_gate_on  <= 1'b0;
                r_gate_off <= 1'b0;
                if (w_load) begin
                    r_s        <= w_s_new;
                    r_len      <= w_len_cfg;
                    r_fin      <= (w_len_cfg == '0);
                    r_gate     <= w_open0;
                    r_gate_on  <= w_open0;
                    r_gate_off <= r_gate;
                end else if (w_abort) begin
                    r_gate     <= 1'b0;
                    r_gate_off <= r_gate;
                end else if (w_run_tick) begin
                    if (w_hit_close) begin
                        r_gate     <= 1'b0;
                        r_gate_on  <= w_hit_open;
                        r_gate_off <= 1'b1;
                        r_fin      <= 1'b1;
                    end else if (w_hit_open) begin
                        r_gate    <= 1'b1;
                        r_gate_on <= 1'b1;
                    end
                end
            end
        end

        assign gate[gi]     = r_gate;
        assign gate_on[gi]  = r_gate_on;
        assign gate_off[gi] = r_gate_off;
    end

    assign busy     = (r_state == ST_RUN);
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign tick_cnt = r_tick_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sync_gate_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_gate_gen
// Description : Self-checking bench for sync_gate_gen against a tick-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_gate_gen;

    localparam int NCH   = 2;
    localparam int CNT_W = 4;
    localparam int MAXC  = 15;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 t8us = 1'b0;
    logic                 tnc = 1'b0;
    logic                 arm = 1'b0;
    logic [NCH*CNT_W-1:0] cfg_start = '0;
    logic [NCH*CNT_W-1:0] cfg_len = '0;
    logic [NCH*CNT_W-1:0] cfg_step = '0;
    logic [NCH-1:0]       gate, gate_on, gate_off;
    logic                 busy, done, overrun;
    logic [CNT_W-1:0]     tick_cnt;
    logic [12:0]          obs;

    int checks = 0;
    int errors = 0;

    int m_start[NCH], m_lcfg[NCH], m_step[NCH];
    int m_off[NCH], m_s[NCH], m_len[NCH];
    int m_cnt = 0;
    bit m_busy = 0, m_ovr = 0, e_done = 0;
    bit [NCH-1:0] e_gate = '0, e_on = '0, e_off = '0;

    sync_gate_gen #(.NCH(NCH), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .t8us(t8us), .tnc(tnc), .arm(arm),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_step(cfg_step),
        .gate(gate), .gate_on(gate_on), .gate_off(gate_off),
        .busy(busy), .done(done), .overrun(overrun), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {tick_cnt, gate, gate_on, gate_off, busy, done, overrun};

    // ---------------- reference model ----------------
    function automatic int close_pt(input int i);
        return (m_s[i] + m_len[i] > MAXC) ? MAXC : m_s[i] + m_len[i];
    endfunction

    function automatic logic [12:0] exp_vec();
        return {CNT_W'(m_cnt), e_gate, e_on, e_off, m_busy, e_done, m_ovr};
    endfunction

    task automatic update_gates();
        for (int i = 0; i < NCH; i++)
            e_gate[i] = m_busy && m_len[i] != 0 && m_s[i] <= m_cnt && m_cnt < close_pt(i);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_busy = 0; m_ovr = 0; e_done = 0;
        e_gate = '0; e_on = '0; e_off = '0;
        for (int i = 0; i < NCH; i++) begin m_off[i] = 0; m_s[i] = 0; m_len[i] = 0; end
    endtask

    task automatic model_tnc_event();
        e_on = '0; e_off = '0; e_done = 0;
        if (m_busy) begin
            m_ovr = 1;
            e_off = e_gate;
        end
        m_cnt = 0;
        m_busy = 1;
        for (int i = 0; i < NCH; i++) begin
            m_s[i]   = m_start[i] + m_off[i];
            m_len[i] = m_lcfg[i];
            m_off[i] = (m_off[i] + m_step[i]) % (MAXC + 1);
            e_on[i]  = (m_len[i] != 0) && (m_s[i] == 0);
        end
        update_gates();
    endtask

    task automatic model_tick_event();
        bit all_fin;
        e_on = '0; e_off = '0; e_done = 0;
        if (!m_busy) return;
        if (m_cnt < MAXC) m_cnt++;
        all_fin = 1;
        for (int i = 0; i < NCH; i++) begin
            if (m_len[i] != 0) begin
                if (m_cnt == m_s[i]) e_on[i] = 1;
                if (m_s[i] <= MAXC && m_cnt == close_pt(i)) e_off[i] = 1;
                if (!(m_s[i] <= MAXC && m_cnt >= close_pt(i))) all_fin = 0;
            end
        end
        if (all_fin || m_cnt == MAXC) begin
            m_busy = 0;
            e_done = 1;
        end
        update_gates();
    endtask

    task automatic model_arm_low();
        e_on = '0;
        e_off = m_busy ? e_gate : '0;
        e_done = m_busy;
        m_busy = 0; m_ovr = 0;
        for (int i = 0; i < NCH; i++) m_off[i] = 0;
        update_gates();
    endtask

    // ---------------- stimulus drivers ----------------
    task automatic set_ch(input int i, input int st, input int ln, input int sp);
        logic [CNT_W-1:0] v;
        m_start[i] = st; m_lcfg[i] = ln; m_step[i] = sp;
        v = CNT_W'(st); cfg_start[i*CNT_W +: CNT_W] = v;
        v = CNT_W'(ln); cfg_len[i*CNT_W +: CNT_W]   = v;
        v = CNT_W'(sp); cfg_step[i*CNT_W +: CNT_W]  = v;
    endtask

    // High for two clocks; returns 1 time unit after the registration edge.
    task automatic strobe(input bit do_tnc, input bit do_tick);
        repeat (2) @(negedge clk);
        tnc = do_tnc; t8us = do_tick;
        repeat (2) @(negedge clk);
        tnc = 1'b0; t8us = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_tick();  strobe(0, 1); model_tick_event(); endtask
    task automatic do_tnc();   strobe(1, 0); model_tnc_event();  endtask
    task automatic do_both();  strobe(1, 1); model_tnc_event();  endtask

    task automatic drive_arm(input bit v);
        @(negedge clk); arm = v;
        @(posedge clk); #1;
        if (!v) model_arm_low();
        else begin e_on = '0; e_off = '0; e_done = 0; end
    endtask

    task automatic rearm();
        drive_arm(0);
        drive_arm(1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (obs !== 13'b0) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, 13'b0); end
        @(negedge clk); rst_n = 1'b1; arm = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int on_at = -1, off_at = -1, done_at = -1, on1 = 0;
        rearm();
        set_ch(0, 3, 4, 0); set_ch(1, 5, 0, 0);
        do_tnc();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL basic_start: got %b expected %b", obs, exp_vec()); end
        for (int t = 1; t <= 10; t++) begin
            do_tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL basic_tick%0d: got %b expected %b", t, obs, exp_vec()); end
            if (gate_on[0])  on_at   = int'(tick_cnt);
            if (gate_off[0]) off_at  = int'(tick_cnt);
            if (done)        done_at = int'(tick_cnt);
            if (gate_on[1])  on1++;
        end
        checks++;
        if (on_at != 3 || off_at != 7 || done_at != 7 || on1 != 0) begin
            errors++;
            $display("FAIL basic_points: got on=%0d off=%0d done=%0d ch1_on=%0d expected on=3 off=7 done=7 ch1_on=0",
                     on_at, off_at, done_at, on1);
        end
    endtask

    task automatic test_start_zero();
        rearm();
        set_ch(0, 0, 2, 0); set_ch(1, 0, 0, 0);
        do_tnc();
        checks++;
        if (gate[0] !== 1'b1 || gate_on[0] !== 1'b1 || tick_cnt !== 4'd0) begin
            errors++;
            $display("FAIL start_zero_open: got gate=%b on=%b cnt=%0d expected gate=1 on=1 cnt=0", gate[0], gate_on[0], tick_cnt);
        end
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL start_zero_tick%0d: got %b expected %b", t, obs, exp_vec()); end
        end
    endtask

    task automatic test_scan();
        int seen;
        rearm();
        set_ch(0, 1, 1, 2); set_ch(1, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) rearm();
            do_tnc();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL scan%0d_start: got %b expected %b", c, obs, exp_vec()); end
            seen = -1;
            for (int t = 0; t < 8 && m_busy; t++) begin
                do_tick();
                checks++;
                if (obs !== exp_vec()) begin errors++; $display("FAIL scan%0d_tick: got %b expected %b", c, obs, exp_vec()); end
                if (gate_on[0]) seen = int'(tick_cnt);
            end
            checks++;
            if (seen != ((c < 3) ? 1 + 2 * c : 1)) begin
                errors++;
                $display("FAIL scan%0d_open: got %0d expected %0d", c, seen, (c < 3) ? 1 + 2 * c : 1);
            end
        end
    endtask

    task automatic test_overrun();
        rearm();
        set_ch(0, 2, 5, 0); set_ch(1, 0, 0, 0);
        do_tnc();
        for (int t = 1; t <= 4; t++) do_tick();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL ovr_pre: got %b expected %b", obs, exp_vec()); end
        do_tnc();
        checks++;
        if (overrun !== 1'b1 || gate_off[0] !== 1'b1 || gate[0] !== 1'b0 || tick_cnt !== 4'd0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_restart: got ovr=%b off=%b gate=%b cnt=%0d done=%b busy=%b expected 1 1 0 0 0 1",
                     overrun, gate_off[0], gate[0], tick_cnt, done, busy);
        end
        for (int t = 0; t < 16 && m_busy; t++) begin
            do_tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL ovr_tick%0d: got %b expected %b", t, obs, exp_vec()); end
        end
        drive_arm(0);
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL ovr_clear: got %b expected %b", obs, exp_vec()); end
        drive_arm(1);
    endtask

    task automatic test_tnc_tick_same();
        rearm();
        set_ch(0, 2, 5, 0); set_ch(1, 0, 0, 0);
        do_tnc();
        for (int t = 1; t <= 3; t++) do_tick();
        do_both();
        checks++;
        if (tick_cnt !== 4'd0 || busy !== 1'b1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL same_run: got %b expected %b", obs, exp_vec());
        end
        for (int t = 0; t < 16 && m_busy; t++) do_tick();
        rearm();
        do_both();
        checks++;
        if (tick_cnt !== 4'd0 || busy !== 1'b1 || overrun !== 1'b0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL same_idle: got %b expected %b", obs, exp_vec());
        end
        for (int t = 0; t < 16 && m_busy; t++) do_tick();
    endtask

    task automatic test_saturation();
        int on_at = -1, off_at = -1, done_at = -1;
        rearm();
        set_ch(0, 14, 5, 0); set_ch(1, 0, 0, 0);
        do_tnc();
        for (int t = 1; t <= 16; t++) begin
            do_tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL sat_tick%0d: got %b expected %b", t, obs, exp_vec()); end
            if (gate_on[0])  on_at   = int'(tick_cnt);
            if (gate_off[0]) off_at  = int'(tick_cnt);
            if (done)        done_at = int'(tick_cnt);
        end
        checks++;
        if (on_at != 14 || off_at != 15 || done_at != 15) begin
            errors++;
            $display("FAIL sat_points: got on=%0d off=%0d done=%0d expected 14 15 15", on_at, off_at, done_at);
        end
    endtask

    task automatic test_reset_mid();
        rearm();
        set_ch(0, 1, 5, 0);
        do_tnc();
        for (int t = 1; t <= 3; t++) do_tick();
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== 13'b0) begin errors++; $display("FAIL reset_mid: got %b expected %b", obs, 13'b0); end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      do_tick();
            else if (r < 75) do_tnc();
            else if (r < 82) do_both();
            else if (r < 88) drive_arm(0);
            else begin
                set_ch(0, $urandom_range(0, 15), $urandom_range(1, 6), $urandom_range(0, 15));
                set_ch(1, $urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 15));
                @(posedge clk); #1;
                e_on = '0; e_off = '0; e_done = 0;
            end
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rand_op%0d: got %b expected %b", n, obs, exp_vec()); end
            if (!arm) drive_arm(1);
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) set_ch(i, 0, 0, 0);
        model_reset();
        test_reset();
        test_basic();
        test_start_zero();
        test_scan();
        test_overrun();
        test_tnc_tick_same();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_gate_gen.md
# sync_gate_gen

Parametrised multi-channel synchroniser gate generator for the radar timing subsystem. On each cycle-start strobe it counts 8 µs tick strobes and drives per-channel gates (emission, reception, auxiliary) from programmable start/length codes. Each channel can move its start position by a fixed step every cycle for scanning modes. Overlapping cycle starts are detected and flagged.

## Interface
- `NCH`, default 4: number of gate channels (≥1)
- `CNT_W`, default 16: width of tick counter and all codes
- `clk` in, 1: system clock
- `rst_n` in, 1: synchronous reset, active-low
- `t8us` in, 1: asynchronous 8 µs tick strobe; rising edge counts
- `tnc` in, 1: asynchronous cycle-start strobe; rising edge starts a cycle
- `arm` in, 1: enable; while low, cycle starts are ignored and offsets are held at 0
- `cfg_start` in, NCH*CNT_W: per-channel start code, in ticks; channel i is bits [i*CNT_W +: CNT_W]
- `cfg_len` in, NCH*CNT_W: per-channel gate length, in ticks; 0 disables the channel
- `cfg_step` in, NCH*CNT_W: per-channel start increment per cycle, unsigned, modulo 2^CNT_W
- `gate` out, NCH: channel gate level
- `gate_on` / `gate_off` out, NCH each: 1-clk pulse when the gate opens / closes
- `busy` out, 1: a cycle is in progress
- `done` out, 1: 1-clk pulse at the end of a cycle
- `overrun` out, 1: sticky; set when a cycle start arrives while busy; cleared by `rst_n` or `arm`=0
- `tick_cnt` out, CNT_W: current tick count

## Operation
- Reset (`rst_n`=0 at clk edge): all outputs 0, state IDLE, offsets 0, synchroniser registers 0.
- Both strobes pass through a 3-flop shift; an event is registered when the pattern is old/mid/new = 0/1/1.
- States:
  - IDLE: on a `tnc` event with `arm`=1, go to RUN.
  - RUN: go to IDLE when every enabled channel has closed, or when `tick_cnt` saturates at all-ones.
- Cycle start (`tnc` event, `arm`=1):
  - `tick_cnt` ← 0.
  - Latch `cfg_len` per channel.
  - Latch s_i = cfg_start_i + off_i, computed in CNT_W+1 bits.
  - Then off_i ← off_i + cfg_step_i, modulo 2^CNT_W.
- Tick event in RUN: `tick_cnt` ← `tick_cnt` + 1, saturating at 2^CNT_W−1.
- Channel i opens (`gate`=1, `gate_on` pulse) when `tick_cnt` = s_i. The comparison is evaluated at the cycle start (count 0) and at every tick.
- Channel i closes (`gate`=0, `gate_off` pulse) when `tick_cnt` = s_i + len_i (CNT_W+1-bit sum).
- Channel i never opens when s_i > 2^CNT_W−1.
- If s_i + len_i > 2^CNT_W−1, channel i closes on the tick where `tick_cnt` saturates.
- len_i = 0: the channel never opens and counts as already closed.
- `done` pulses on the RUN→IDLE transition.
- `tnc` event during RUN:
  - Set `overrun`.
  - Force open gates closed, with `gate_off` pulses in the same cycle.
  - Restart the cycle in the same cycle as a normal cycle start; offsets advance. `done` is not pulsed.
- `tnc` and `t8us` events in the same clk: `tnc` wins and the tick is discarded.
- `arm` falling during RUN: treated as abort. Gates close with `gate_off` pulses, state goes to IDLE, `done` pulses.
- Reset during RUN: all outputs drop to 0 immediately; no pulses are emitted.
- `cfg_*` may change at any time; only the values latched at cycle start are used.

## Timing
- Strobe sampled high first at clk edge k → registered effect at edge k+2.
- `tick_cnt`, `gate`, `gate_on`/`gate_off` and `busy` all update at that same edge.
- Gate changes are coincident with the `tick_cnt` change that causes them; zero additional latency.
- `done` is asserted in the same cycle that `busy` falls.
- Minimum strobe high and low time: 2 clk.

## Structure
- Package `sync_gate_pkg`: state enum (IDLE, RUN) and default `CNT_W` constant.
- Sub-module `sync_edge_det`: 3-flop synchroniser plus rising-edge pulse; instantiated for `t8us` and `tnc`.
- Channel logic is a generate loop inside `sync_gate_gen`.

## Test plan
- NCH=2, start={3,5}, len={4,0}, step=0, arm=1; one `tnc`, then 10 ticks:
  - ch0 opens at tick_cnt=3 and closes at 7.
  - ch1 never opens.
  - `done` pulses at tick 7.
- start=0, len=2: gate opens at the `tnc` registration edge (k+2) with tick_cnt=0.
- step=2, start=1, len=1, three cycles: openings at ticks 1, 3, 5.
  - Then drop `arm` and re-arm: next opening at tick 1 again.
- `tnc` again at tick 4 while ch0 is open:
  - `overrun`=1.
  - `gate_off` pulse and restart in the same cycle.
  - tick_cnt=0; no `done` pulse.
- `tnc` and `t8us` rise on the same clk: tick_cnt=0 after registration; the tick is not counted.
- CNT_W=4, start=14, len=5: ch0 opens at 14 and closes when tick_cnt saturates at 15; `done` pulses.
  - Assert `rst_n`=0 mid-gate: all outputs 0 on the next edge.
